// File: rtl/mini_mips_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mini_mips_mem_pkg: shared state encoding and geometry defaults        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package mini_mips_mem_pkg;

  localparam int c_addr_w = 8;
  localparam int c_data_w = 8;
  localparam int c_depth  = 256;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mini_mips_ram256.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mini_mips_ram256: byte store, one write port, asynchronous read       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module mini_mips_ram256
  import mini_mips_mem_pkg::*;
#(
  parameter int ADDR_W = c_addr_w,
  parameter int DATA_W = c_data_w,
  parameter int DEPTH  = c_depth
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/mini_mips_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mini_mips_mem_responder: clears memory, accepts a host preload, then  |
// | serves CPU byte reads/writes. Revision: 1.0                           |
// +----------------------------------------------------------------------+
module mini_mips_mem_responder
  import mini_mips_mem_pkg::*;
#(
  parameter int ADDR_W = c_addr_w,
  parameter int DATA_W = c_data_w,
  parameter int DEPTH  = c_depth
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] adr,
  input  logic              memwrite,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] memdata,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              cpu_hold,
  output logic [15:0]       wr_count
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_ptr;

  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata;

  // Single write port: the owner of the port follows the phase.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_clr_ptr;
    w_wdata = '0;
    case (r_state)
      CLEAR: w_we = 1'b1;
      LOAD: begin
        w_we    = ld_valid & ld_ready;
        w_waddr = ld_addr;
        w_wdata = ld_data;
      end
      RUN: begin
        w_we    = memwrite;
        w_waddr = adr;
        w_wdata = writedata;
      end
      default: w_we = 1'b0;
    endcase
  end

  mini_mips_ram256 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (adr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= CLEAR;
      r_clr_ptr <= '0;
      memdata   <= '0;
      wr_count  <= '0;
      ld_ready  <= 1'b0;
      cpu_hold  <= 1'b1;
    end else begin
      case (r_state)
        CLEAR: begin
          r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
          if (r_clr_ptr == ADDR_W'(DEPTH - 1)) begin
            r_state  <= LOAD;
            ld_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (ld_valid && ld_ready && ld_last) begin
            r_state  <= RUN;
            ld_ready <= 1'b0;
            cpu_hold <= 1'b0;
          end
        end
        RUN: begin
          // Write-first: a store returns the byte being written.
          memdata <= memwrite ? writedata : w_rdata;
          if (memwrite && (wr_count != 16'hFFFF)) begin
            wr_count <= wr_count + 16'd1;
          end
        end
        default: begin
          r_state   <= CLEAR;
          r_clr_ptr <= '0;
          ld_ready  <= 1'b0;
          cpu_hold  <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mini_mips_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mini_mips_mem_responder: directed stimulus with queued expectations|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_mini_mips_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  adr;
  logic        memwrite;
  logic [7:0]  writedata;
  logic [7:0]  memdata;
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_addr;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        cpu_hold;
  logic [15:0] wr_count;

  always #5 clk = ~clk;

  mini_mips_mem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .adr       (adr),
    .memwrite  (memwrite),
    .writedata (writedata),
    .memdata   (memdata),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .cpu_hold  (cpu_hold),
    .wr_count  (wr_count)
  );

  // mask bits: [3] memdata, [2] wr_count, [1] ld_ready, [0] cpu_hold
  typedef struct {
    string       name;
    int          cyc;
    logic [3:0]  mask;
    logic [7:0]  md;
    logic [15:0] wc;
    logic        rdy;
    logic        hold;
  } exp_t;

  exp_t q[$];
  int   mon_cyc  = 0;
  int   errors   = 0;
  int   checks   = 0;
  int   wc_model = 0;

  task automatic expect_nx(input string name, input logic [3:0] mask, input logic [7:0] md,
                           input logic [15:0] wc, input logic rdy, input logic hold);
    exp_t e;
    e.name = name;
    e.cyc  = mon_cyc + 1;
    e.mask = mask;
    e.md   = md;
    e.wc   = wc;
    e.rdy  = rdy;
    e.hold = hold;
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      mon_cyc++;
      while (q.size() > 0 && q[0].cyc <= mon_cyc) begin
        e = q.pop_front();
        if (e.cyc != mon_cyc) begin
          checks++;
          errors++;
          $display("FAIL %s: expectation for cycle %0d seen at %0d", e.name, e.cyc, mon_cyc);
        end else begin
          if (e.mask[3]) begin
            checks++;
            if (memdata !== e.md) begin
              errors++;
              $display("FAIL %s memdata: got %h want %h (cyc %0d)", e.name, memdata, e.md, mon_cyc);
            end
          end
          if (e.mask[2]) begin
            checks++;
            if (wr_count !== e.wc) begin
              errors++;
              $display("FAIL %s wr_count: got %h want %h (cyc %0d)", e.name, wr_count, e.wc, mon_cyc);
            end
          end
          if (e.mask[1]) begin
            checks++;
            if (ld_ready !== e.rdy) begin
              errors++;
              $display("FAIL %s ld_ready: got %b want %b (cyc %0d)", e.name, ld_ready, e.rdy, mon_cyc);
            end
          end
          if (e.mask[0]) begin
            checks++;
            if (cpu_hold !== e.hold) begin
              errors++;
              $display("FAIL %s cpu_hold: got %b want %b (cyc %0d)", e.name, cpu_hold, e.hold, mon_cyc);
            end
          end
        end
      end
    end
  end

  task automatic do_reset(input int n);
    reset = 1'b0;
    for (int k = 0; k < n; k++) begin
      expect_nx("reset", 4'b1111, 8'h00, 16'h0000, 1'b0, 1'b1);
      @(negedge clk);
    end
    reset    = 1'b1;
    wc_model = 0;
  endtask

  task automatic clear_sweep(input string tag);
    for (int k = 0; k < 256; k++) begin
      expect_nx(tag, 4'b1111, 8'h00, 16'h0000, (k == 255), 1'b1);
      @(negedge clk);
    end
  endtask

  task automatic ld(input logic [7:0] a, input logic [7:0] d, input logic last);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    ld_last  = last;
    expect_nx("load", 4'b1111, 8'h00, 16'h0000, ~last, ~last);
    @(negedge clk);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic rd(input string name, input logic [7:0] a, input logic [7:0] d);
    memwrite = 1'b0;
    adr      = a;
    expect_nx(name, 4'b1111, d, 16'(wc_model), 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task automatic wr(input string name, input logic [7:0] a, input logic [7:0] d, input bit chk);
    memwrite  = 1'b1;
    adr       = a;
    writedata = d;
    if (wc_model < 65535) wc_model++;
    if (chk) expect_nx(name, 4'b1111, d, 16'(wc_model), 1'b0, 1'b0);
    @(negedge clk);
    memwrite = 1'b0;
  endtask

  initial begin
    reset = 1'b0; adr = '0; memwrite = 1'b0; writedata = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0;
    @(negedge clk);
    do_reset(2);

    // Host and CPU traffic during the sweep must be ignored.
    ld_valid = 1'b1; ld_addr = 8'h05; ld_data = 8'hAA; ld_last = 1'b1;
    memwrite = 1'b1; adr = 8'h30; writedata = 8'h55;
    clear_sweep("clear1");
    ld_valid = 1'b0; ld_last = 1'b0;

    // CPU write attempt while loading.
    memwrite = 1'b1; adr = 8'h20; writedata = 8'h77;
    expect_nx("load_cpuwr", 4'b1111, 8'h00, 16'h0000, 1'b1, 1'b1);
    @(negedge clk);
    memwrite = 1'b0;

    ld(8'h00, 8'h00, 1'b0);
    ld(8'h01, 8'hBF, 1'b0);
    ld(8'h02, 8'h11, 1'b0);
    ld(8'h02, 8'hCC, 1'b0);
    ld_addr = 8'h03; ld_data = 8'hEE;
    expect_nx("load_idle", 4'b1111, 8'h00, 16'h0000, 1'b1, 1'b1);
    @(negedge clk);
    ld(8'h03, 8'h80, 1'b1);

    // Host valid in RUN must not write.
    ld_valid = 1'b1; ld_addr = 8'h04; ld_data = 8'hEE;
    rd("rd0", 8'h00, 8'h00);
    ld_valid = 1'b0;
    rd("rd1", 8'h01, 8'hBF);
    rd("rd2", 8'h02, 8'hCC);
    rd("rd3", 8'h03, 8'h80);
    rd("rd4", 8'h04, 8'h00);
    rd("rd5", 8'h05, 8'h00);
    rd("rd20", 8'h20, 8'h00);
    rd("rd30", 8'h30, 8'h00);

    wr("wr10", 8'h10, 8'h66, 1'b1);
    rd("rd0b", 8'h00, 8'h00);
    rd("rd10", 8'h10, 8'h66);

    for (int i = 0; i < 65536; i++) begin
      wr("sat", 8'h40, 8'(i), (i < 3) || (i >= 65530));
    end
    rd("rd40", 8'h40, 8'hFF);
    rd("rd10b", 8'h10, 8'h66);

    // Reset from RUN, then reset again mid-LOAD.
    do_reset(1);
    clear_sweep("clear2");
    ld(8'h08, 8'h12, 1'b0);
    ld(8'h09, 8'h34, 1'b0);
    do_reset(2);
    clear_sweep("clear3");
    ld(8'hFF, 8'h5A, 1'b1);
    rd("rd8", 8'h08, 8'h00);
    rd("rd9", 8'h09, 8'h00);
    rd("rdff", 8'hFF, 8'h5A);
    rd("rd10c", 8'h10, 8'h00);
    rd("rd40b", 8'h40, 8'h00);
    rd("rd2b", 8'h02, 8'h00);

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mini_mips_mem_responder.md
MINI_MIPS_MEM_RESPONDER -- requirements
Module: mini_mips_mem_responder

Interface
REQ-001 Parameter ADDR_W, default 8, byte address width.
REQ-002 Parameter DATA_W, default 8, byte data width.
REQ-003 Parameter DEPTH, default 256, number of bytes stored; SHALL equal 2**ADDR_W.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset (0 = reset asserted).
REQ-006 adr  input  ADDR_W  CPU byte address.
REQ-007 memwrite  input  1  CPU byte write strobe.
REQ-008 writedata  input  DATA_W  CPU write byte.
REQ-009 memdata  output  DATA_W  registered read byte returned to CPU.
REQ-010 ld_valid  input  1  host preload byte valid.
REQ-011 ld_ready  output  1  responder accepts a preload byte this cycle.
REQ-012 ld_addr  input  ADDR_W  preload byte address.
REQ-013 ld_data  input  DATA_W  preload byte.
REQ-014 ld_last  input  1  qualifies the final preload byte; sampled only on a handshake.
REQ-015 cpu_hold  output  1  holds the CPU in reset while 1.
REQ-016 wr_count  output  16  count of accepted CPU writes.

Function
REQ-017 The FSM SHALL have exactly three states: CLEAR, LOAD, RUN.
REQ-018 CLEAR: one write of 0x00 per cycle at clr_ptr = 0..DEPTH-1; after the write at DEPTH-1, next state LOAD.
REQ-019 CLEAR SHALL take exactly DEPTH cycles; the first LOAD cycle is cycle DEPTH after reset release, counting from cycle 0.
REQ-020 LOAD: ld_ready = 1; a handshake (ld_valid & ld_ready) writes ld_data to mem[ld_addr] that edge.
REQ-021 A LOAD handshake with ld_last = 1 SHALL move the FSM to RUN on the same edge.
REQ-022 Repeated handshakes to one ld_addr: the last one wins.
REQ-023 ld_ready SHALL be 0 in CLEAR and RUN; ld_valid in those states is ignored.
REQ-024 cpu_hold SHALL be 1 in CLEAR and LOAD, and 0 in RUN.
REQ-025 RUN: memwrite = 1 writes writedata to mem[adr] on the edge.
REQ-026 RUN: memdata is updated every edge to mem[adr], giving one-cycle read latency.
REQ-027 RUN, memwrite = 1: memdata gets writedata (write-first read).
REQ-028 memdata SHALL be 0x00 in CLEAR and LOAD.
REQ-029 memwrite in CLEAR or LOAD SHALL be ignored: no write, no count.
REQ-030 Each RUN write increments wr_count by 1; wr_count saturates at 0xFFFF.
REQ-031 The write port SHALL be muxed by state (CLEAR zeros / LOAD host / RUN CPU); one write per cycle at most.
REQ-032 RUN is terminal; only reset leaves it.

Reset
REQ-033 While reset = 0 at a rising edge: state becomes CLEAR, clr_ptr 0, memdata 0x00, wr_count 0, ld_ready 0, cpu_hold 1.
REQ-034 Reset mid-CLEAR, mid-LOAD or in RUN SHALL restart CLEAR from address 0.
REQ-035 A partially loaded image SHALL NOT survive reset.
REQ-036 Memory contents need no reset beyond the CLEAR sweep.

Structure
REQ-037 Shared package mini_mips_mem_pkg SHALL hold the state encoding (CLEAR, LOAD, RUN) and the defaults of ADDR_W, DATA_W and DEPTH.
REQ-038 Storage SHALL be one sub-module, mini_mips_ram256: one write port, asynchronous read, no reset.
REQ-039 The FSM, write mux, memdata register and wr_count SHALL reside in mini_mips_mem_responder.

Verification
REQ-040 Release reset -> ld_ready = 0, cpu_hold = 1 for cycles 0..255; ld_ready = 1 at cycle 256.
REQ-041 LOAD bytes 0x00, 0xBF, 0xCC, 0x80 at 0..3, last on 3 -> cpu_hold 0; adr 0..3 then returns those bytes one cycle later; adr 4 returns 0x00.
REQ-042 RUN, memwrite = 1, adr 0x10, writedata 0x66 -> memdata 0x66 the next cycle, wr_count = 1, and a later read of 0x10 returns 0x66.
REQ-043 memwrite pulsed in LOAD with adr 0x20, writedata 0x77 -> mem[0x20] stays 0x00, wr_count stays 0.
REQ-044 Drop reset after two LOAD handshakes, then release -> CLEAR repeats for 256 cycles and the loaded bytes read as 0x00 after RUN.
REQ-045 Force wr_count = 0xFFFE, then do two writes -> wr_count holds 0xFFFF.
